dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: ARQ, default 16, data word width; MEMORY_ADDR_SIZE, default 13, address width; STARVE_MAX, default 4, number of consecutive host losses before host is given priority.
REQ-002 The design SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- cpu_rd_en  in  1  CPU MEM-stage read request
- cpu_wr_en  in  1  CPU MEM-stage write request
- cpu_addr  in  MEMORY_ADDR_SIZE  CPU address
- cpu_wdata  in  ARQ  CPU write data
- cpu_stall  out  1  CPU request not granted this cycle; pipeline holds pc_en low
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  ARQ  CPU read data
- host_req  in  1  host loader request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  MEMORY_ADDR_SIZE  host address
- host_wdata  in  ARQ  host write data
- host_gnt  out  1  host request accepted this cycle
- host_rvalid  out  1  host_rdata valid
- host_rdata  out  ARQ  host read data
- mem_rd_en  out  1  memory read strobe
- mem_wr_en  out  1  memory write strobe
- mem_addr  out  MEMORY_ADDR_SIZE  memory address
- mem_wdata  out  ARQ  memory write data
- mem_rdata  in  ARQ  memory read data, 1-cycle latency after mem_rd_en

Function
REQ-004 The block SHALL issue at most one memory access per cycle; grant decision and mem_* outputs are combinational from the current requests and the registered state.
REQ-005 A CPU request is active when cpu_rd_en or cpu_wr_en is 1; if both are 1, the access SHALL be a write and the read SHALL be dropped, with no rvalid.
REQ-006 The FSM SHALL have states PRIO_CPU (reset state) and PRIO_HOST.
REQ-007 In PRIO_CPU: CPU active -> CPU granted; otherwise host_req -> host granted.
REQ-008 In PRIO_HOST: host_req -> host granted; otherwise CPU active -> CPU granted.
REQ-009 A registered wait_cnt SHALL increment when host_req=1 and host_gnt=0, and clear to 0 when host_gnt=1; it saturates at STARVE_MAX.
REQ-010 PRIO_CPU -> PRIO_HOST SHALL occur on the edge where wait_cnt becomes STARVE_MAX; PRIO_HOST -> PRIO_CPU SHALL occur on the edge after host_gnt=1, or when host_req=0 in PRIO_HOST.
REQ-011 cpu_stall SHALL be 1 exactly when CPU is active and not granted; host_gnt SHALL be 1 exactly when host is granted.
REQ-012 Granted access SHALL drive mem_addr and mem_wdata from the winner and set mem_rd_en or mem_wr_en accordingly; with no grant, all mem_* outputs SHALL be 0.
REQ-013 For a granted read, a registered owner tag SHALL assert the owner's rvalid in the next cycle only, with its rdata = mem_rdata; the other rdata SHALL be 0.
REQ-014 Back-to-back reads from either requester SHALL sustain one result per cycle with no bubble.
REQ-015 A write SHALL produce no rvalid.

Reset
REQ-016 While rst=1 on a clock edge: FSM -> PRIO_CPU, wait_cnt -> 0, owner tag cleared, cpu_rvalid=host_rvalid=0 in the following cycle.
REQ-017 While rst=1, all grant and mem_* outputs SHALL be forced to 0 regardless of requests. A read granted in the cycle before rst is asserted SHALL NOT produce rvalid.

Verification
REQ-018 Scenario, CPU-only read: cpu_rd_en=1, cpu_addr=0x0010, mem_rdata=0xBEEF next cycle -> mem_rd_en=1, mem_addr=0x0010, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=0xBEEF.
REQ-019 Scenario, contention in PRIO_CPU: cpu_wr_en=1, addr 0x0005, wdata 0x1234, with host_req=1 -> mem_wr_en=1, mem_wdata=0x1234, host_gnt=0, wait_cnt=1.
REQ-020 Scenario, starvation: CPU and host both request for 5 cycles with STARVE_MAX=4 -> CPU granted in cycles 1-4; host_gnt=1 and cpu_stall=1 in cycle 5; FSM back to PRIO_CPU in cycle 6.
REQ-021 Scenario, dual CPU enable: cpu_rd_en=cpu_wr_en=1, addr 0x1FFF -> mem_wr_en=1, mem_rd_en=0, no cpu_rvalid next cycle.
REQ-022 Scenario, reset mid-read: host read granted at cycle N, rst=1 at cycle N+1 -> host_rvalid=0 at N+1 and N+2; all outputs 0 while rst=1.
REQ-023 Scenario, pipelined reads: host reads 0x0000, 0x0001, 0x0002 on consecutive cycles, no CPU requests -> host_rvalid=1 for 3 consecutive cycles, starting one cycle after the first grant.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a host loader.
// CPU has priority until the host has lost STARVE_MAX times in a row.
module dmem_arbiter #(
  parameter int ARQ              = 16,
  parameter int MEMORY_ADDR_SIZE = 13,
  parameter int STARVE_MAX       = 4,
  localparam int WCW             = $clog2(STARVE_MAX + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_rd_en,
  input  logic                        cpu_wr_en,
  input  logic [MEMORY_ADDR_SIZE-1:0] cpu_addr,
  input  logic [ARQ-1:0]              cpu_wdata,
  output logic                        cpu_stall,
  output logic                        cpu_rvalid,
  output logic [ARQ-1:0]              cpu_rdata,
  input  logic                        host_req,
  input  logic                        host_we,
  input  logic [MEMORY_ADDR_SIZE-1:0] host_addr,
  input  logic [ARQ-1:0]              host_wdata,
  output logic                        host_gnt,
  output logic                        host_rvalid,
  output logic [ARQ-1:0]              host_rdata,
  output logic                        mem_rd_en,
  output logic                        mem_wr_en,
  output logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
  output logic [ARQ-1:0]              mem_wdata,
  input  logic [ARQ-1:0]              mem_rdata,
  output logic                        dbg_prio_host_o,
  output logic [WCW-1:0]              dbg_wait_cnt_o
);

  // Handshake: a requester holds its request until it sees itself granted
  // (cpu_stall=0 / host_gnt=1); read data returns exactly one cycle later
  // qualified by that requester's rvalid.
  typedef enum logic {PRIO_CPU = 1'b0, PRIO_HOST = 1'b1} state_t;

  localparam logic [WCW-1:0] WAIT_MAX = WCW'(STARVE_MAX);

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           tag_cpu_q, tag_cpu_d;
  logic           tag_host_q, tag_host_d;
  logic           cpu_act, cpu_win, host_win, host_loss;

  always_comb begin
    cpu_act  = cpu_rd_en | cpu_wr_en;
    cpu_win  = 1'b0;
    host_win = 1'b0;
    if (!rst) begin
      if (state_q == PRIO_CPU) begin
        if (cpu_act)       cpu_win  = 1'b1;
        else if (host_req) host_win = 1'b1;
      end else begin
        if (host_req)      host_win = 1'b1;
        else if (cpu_act)  cpu_win  = 1'b1;
      end
    end
    host_loss = ~rst & host_req & ~host_win;
  end

  always_comb begin
    cpu_stall = ~rst & cpu_act & ~cpu_win;
    host_gnt  = host_win;
    // A simultaneous read+write from the CPU is treated as a write only.
    mem_rd_en = (cpu_win & ~cpu_wr_en) | (host_win & ~host_we);
    mem_wr_en = (cpu_win & cpu_wr_en) | (host_win & host_we);
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_win) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (host_win) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (host_win)
      wait_cnt_d = '0;
    else if (host_loss && wait_cnt_q != WAIT_MAX)
      wait_cnt_d = wait_cnt_q + 1'b1;

    state_d = state_q;
    case (state_q)
      PRIO_CPU:  if (host_loss && wait_cnt_d == WAIT_MAX) state_d = PRIO_HOST;
      PRIO_HOST: if (host_win || !host_req)               state_d = PRIO_CPU;
      default:   state_d = PRIO_CPU;
    endcase

    tag_cpu_d  = cpu_win & cpu_rd_en & ~cpu_wr_en;
    tag_host_d = host_win & ~host_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PRIO_CPU;
      wait_cnt_q <= '0;
      tag_cpu_q  <= 1'b0;
      tag_host_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tag_cpu_q  <= tag_cpu_d;
      tag_host_q <= tag_host_d;
    end
  end

  // Gating with rst kills a result whose read was granted just before reset.
  always_comb begin
    cpu_rvalid  = tag_cpu_q & ~rst;
    host_rvalid = tag_host_q & ~rst;
    cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
    host_rdata  = host_rvalid ? mem_rdata : '0;
  end

  assign dbg_prio_host_o = (state_q == PRIO_HOST);
  assign dbg_wait_cnt_o  = wait_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle check against a behavioural
// arbitration model plus hand-computed scenario expectations.
module tb_dmem_arbiter;

  localparam int ARQ  = 16;
  localparam int AW   = 13;
  localparam int SMAX = 4;
  localparam int WCW  = $clog2(SMAX + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_rd_en, cpu_wr_en, cpu_stall, cpu_rvalid;
  logic [AW-1:0]   cpu_addr;
  logic [ARQ-1:0]  cpu_wdata, cpu_rdata;
  logic            host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0]   host_addr;
  logic [ARQ-1:0]  host_wdata, host_rdata;
  logic            mem_rd_en, mem_wr_en;
  logic [AW-1:0]   mem_addr;
  logic [ARQ-1:0]  mem_wdata, mem_rdata;
  logic            dbg_prio_host;
  logic [WCW-1:0]  dbg_wait_cnt;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_arbiter #(.ARQ(ARQ), .MEMORY_ADDR_SIZE(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_prio_host_o(dbg_prio_host), .dbg_wait_cnt_o(dbg_wait_cnt)
  );

  // ---------------- memory with 1-cycle read latency ----------------
  logic [ARQ-1:0] mem_m [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = ARQ'(i) ^ 16'hA5A5;
    mem_m[13'h0010] = 16'hBEEF;
  end
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem_m[mem_addr] : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Winner: 0 none, 1 cpu, 2 host. The favoured side wins a contested cycle.
  bit m_prio_host;
  int m_starve;
  logic [ARQ:0] exp_q[$];   // {owner(1=host), data} of the read due next cycle

  function automatic int winner(input bit prio_host);
    bit c = cpu_rd_en | cpu_wr_en;
    if (rst) return 0;
    if (c && host_req) return prio_host ? 2 : 1;
    if (c) return 1;
    if (host_req) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    int w;
    int ns;
    w = winner(m_prio_host);
    if (rst) begin
      m_prio_host <= 1'b0;
      m_starve    <= 0;
      exp_q.delete();
    end else begin
      ns = m_starve;
      if (w == 2) ns = 0;
      else if (host_req) ns = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
      m_starve <= ns;
      if (m_prio_host) m_prio_host <= 1'b0;
      else if (host_req && w != 2 && ns == SMAX) m_prio_host <= 1'b1;
      if (w == 1 && cpu_rd_en && !cpu_wr_en) exp_q.push_back({1'b0, mem_m[cpu_addr]});
      if (w == 2 && !host_we) exp_q.push_back({1'b1, mem_m[host_addr]});
    end
  end

  // ---------------- compare process ----------------
  bit cmp_en = 1'b0;
  always @(negedge clk) if (cmp_en) begin
    int w;
    logic [ARQ:0] e;
    bit ev_c, ev_h;
    logic [ARQ-1:0] ed;
    w = winner(m_prio_host);
    check("m_host_gnt", 32'(host_gnt), 32'(w == 2));
    check("m_cpu_stall", 32'(cpu_stall), 32'(!rst && (cpu_rd_en || cpu_wr_en) && w != 1));
    check("m_mem_rd_en", 32'(mem_rd_en),
          32'((w == 1 && !cpu_wr_en) || (w == 2 && !host_we)));
    check("m_mem_wr_en", 32'(mem_wr_en), 32'((w == 1 && cpu_wr_en) || (w == 2 && host_we)));
    check("m_mem_addr", 32'(mem_addr), (w == 1) ? 32'(cpu_addr) : (w == 2) ? 32'(host_addr) : 0);
    check("m_mem_wdata", 32'(mem_wdata), (w == 1) ? 32'(cpu_wdata) : (w == 2) ? 32'(host_wdata) : 0);
    ev_c = 0; ev_h = 0; ed = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst) begin
        ev_h = e[ARQ];
        ev_c = !e[ARQ];
        ed   = e[ARQ-1:0];
      end
    end
    check("m_cpu_rvalid", 32'(cpu_rvalid), 32'(ev_c));
    check("m_host_rvalid", 32'(host_rvalid), 32'(ev_h));
    check("m_cpu_rdata", 32'(cpu_rdata), ev_c ? 32'(ed) : 0);
    check("m_host_rdata", 32'(host_rdata), ev_h ? 32'(ed) : 0);
    check("m_prio_host", 32'(dbg_prio_host), 32'(m_prio_host));
    check("m_wait_cnt", 32'(dbg_wait_cnt), 32'(m_starve));
  end

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [ARQ-1:0] wd,
                       input logic hr, input logic hwe,
                       input logic [AW-1:0] ha, input logic [ARQ-1:0] hwd);
    @(posedge clk);
    #1;
    rst = r; cpu_rd_en = rd; cpu_wr_en = wr; cpu_addr = a; cpu_wdata = wd;
    host_req = hr; host_we = hwe; host_addr = ha; host_wdata = hwd;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    rst = 1; cpu_rd_en = 1; cpu_wr_en = 0; cpu_addr = 13'h0001; cpu_wdata = '0;
    host_req = 1; host_we = 0; host_addr = 13'h0002; host_wdata = '0;
    m_prio_host = 0; m_starve = 0;

    // reset with live requests: everything held at zero
    @(posedge clk); #1;
    cmp_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 13'h0001, 16'h0, 1, 0, 13'h0002, 16'h0);
      @(negedge clk);
      check("rst_mem_rd_en", 32'(mem_rd_en), 0);
      check("rst_host_gnt", 32'(host_gnt), 0);
      check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
      check("rst_prio", 32'(dbg_prio_host), 0);
    end
    idle();

    // CPU-only read
    drive(0, 1, 0, 13'h0010, 16'h0, 0, 0, '0, '0);
    @(negedge clk);
    check("s18_mem_rd_en", 32'(mem_rd_en), 1);
    check("s18_mem_addr", 32'(mem_addr), 32'h0010);
    check("s18_cpu_stall", 32'(cpu_stall), 0);
    idle();
    @(negedge clk);
    check("s18_cpu_rvalid", 32'(cpu_rvalid), 1);
    check("s18_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);

    // contention in PRIO_CPU
    drive(0, 0, 1, 13'h0005, 16'h1234, 1, 0, 13'h0007, '0);
    @(negedge clk);
    check("s19_mem_wr_en", 32'(mem_wr_en), 1);
    check("s19_mem_wdata", 32'(mem_wdata), 32'h1234);
    check("s19_host_gnt", 32'(host_gnt), 0);
    idle();
    @(negedge clk);
    check("s19_wait_cnt", 32'(dbg_wait_cnt), 1);
    check("s19_no_rvalid", 32'(cpu_rvalid), 0);
    drive(0, 0, 0, '0, '0, 1, 0, 13'h0003, '0);
    @(negedge clk);
    check("clr_host_gnt", 32'(host_gnt), 1);
    idle();
    @(negedge clk);
    check("clr_wait_cnt", 32'(dbg_wait_cnt), 0);
    check("clr_host_rdata", 32'(host_rdata), 32'hA5A6);

    // starvation: 4 CPU wins, host forced through on the 5th
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, AW'(13'h0020 + i), '0, 1, 0, 13'h0100, '0);
      @(negedge clk);
      check("s20_host_gnt", 32'(host_gnt), (i == 4) ? 1 : 0);
      check("s20_cpu_stall", 32'(cpu_stall), (i == 4) ? 1 : 0);
      check("s20_prio", 32'(dbg_prio_host), (i == 4) ? 1 : 0);
    end
    idle();
    @(negedge clk);
    check("s20_back_prio", 32'(dbg_prio_host), 0);
    check("s20_wait_clr", 32'(dbg_wait_cnt), 0);
    check("s20_host_rdata", 32'(host_rdata), 32'hA4A5);

    // dual CPU enable: write wins, read dropped
    drive(0, 1, 1, 13'h1FFF, 16'h5A5A, 0, 0, '0, '0);
    @(negedge clk);
    check("s21_mem_wr_en", 32'(mem_wr_en), 1);
    check("s21_mem_rd_en", 32'(mem_rd_en), 0);
    check("s21_mem_addr", 32'(mem_addr), 32'h1FFF);
    idle();
    @(negedge clk);
    check("s21_no_rvalid", 32'(cpu_rvalid), 0);

    // reset right after a granted host read
    drive(0, 0, 0, '0, '0, 1, 0, 13'h0040, '0);
    @(negedge clk);
    check("s22_host_gnt", 32'(host_gnt), 1);
    drive(1, 1, 0, 13'h0011, '0, 1, 0, 13'h0041, '0);
    @(negedge clk);
    check("s22_rvalid_n1", 32'(host_rvalid), 0);
    check("s22_gnt_rst", 32'(host_gnt), 0);
    check("s22_stall_rst", 32'(cpu_stall), 0);
    check("s22_mem_rst", 32'({mem_rd_en, mem_wr_en, mem_addr}), 0);
    idle();
    @(negedge clk);
    check("s22_rvalid_n2", 32'(host_rvalid), 0);

    // pipelined host reads
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, '0, '0, 1, 0, AW'(i), '0);
      @(negedge clk);
      check("s23_host_gnt", 32'(host_gnt), 1);
      if (i > 0) check("s23_rvalid", 32'(host_rvalid), 1);
    end
    idle();
    @(negedge clk);
    check("s23_rvalid_last", 32'(host_rvalid), 1);
    check("s23_rdata_last", 32'(host_rdata), 32'hA5A7);
    idle();
    @(negedge clk);
    check("s23_rvalid_end", 32'(host_rvalid), 0);

    // mixed traffic, checked by the model only
    for (int i = 0; i < 60; i++) begin
      logic rd_b, wr_b, hr_b, hw_b;
      rd_b = ($urandom_range(0, 2) != 0);
      wr_b = ($urandom_range(0, 3) == 0);
      hr_b = ($urandom_range(0, 2) != 0);
      hw_b = ($urandom_range(0, 3) == 0);
      drive(($urandom_range(0, 29) == 0), rd_b, wr_b, AW'($urandom_range(0, 8191)),
            ARQ'($urandom_range(0, 65535)), hr_b, hw_b,
            AW'($urandom_range(0, 8191)), ARQ'($urandom_range(0, 65535)));
    end
    idle();
    idle();
    @(negedge clk);
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
